// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the single-port memory arbiter:
//   - owner_e      : which requester a memory read belongs to (fetch or data)
//   - ret_entry_t  : one slot of the read-return pipe {valid, owner, oor}
//   - POISON_DEFAULT : word returned for reads outside the memory region
//   - in_region()  : true when a byte address falls inside the memory region
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    // Owner encoding carried alongside each in-flight read.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // One return-pipe slot. valid=0 marks a bubble or a write.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oor;
    } ret_entry_t;

    localparam logic [15:0] POISON_DEFAULT = 16'hDEAD;

    // Widest byte address the region check accepts; callers zero-extend.
    localparam int ADDR_MAX = 32;

    // The memory holds 2^abits words, i.e. byte addresses 0 .. 2^(abits+1)-1.
    // Anything with a bit set above byte-address bit abits lies outside.
    function automatic logic in_region(input logic [ADDR_MAX-1:0] addr,
                                       input int                  abits);
        return (addr >> (abits + 1)) == '0;
    endfunction

endpackage

// File: rtl/arb_ret_pipe.sv
// ---------------------------------------------------------------------------
// arb_ret_pipe
// READ_LAT-deep shift register that carries a descriptor of every memory
// access alongside the memory's own read latency, so that the descriptor
// pops out in the same cycle the memory presents the read word.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset; clears every slot
//   push_entry in   descriptor for the access granted this cycle
//   pop_entry  out  descriptor whose read data is on MEM_DOUT this cycle
// ---------------------------------------------------------------------------
module arb_ret_pipe
    import mem_arb_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  ret_entry_t push_entry,
    output ret_entry_t pop_entry
);

    ret_entry_t stage [READ_LAT];

    // A slot is pushed every cycle (bubbles carry valid=0), so slot k always
    // describes the access that was granted k+1 edges ago. Reset wipes all
    // slots at once so in-flight reads never come back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push_entry;
            for (int i = 1; i < READ_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_entry = stage[READ_LAT-1];

endmodule

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
// Shares one single-port synchronous MemArray between the instruction fetch
// requester (I, read-only) and the data requester (D, read/write).
// Data wins by default; after MAX_DSTREAK consecutive data grants while a
// fetch waits, the fetch is forced through. Reads are tracked through a
// return pipe and routed back to their owner; accesses outside the memory
// region are granted but never touch the memory, and reads of them return
// POISON.
//
// Optional feature (macro ARB_STATS_EN): adds istall_cnt / dstall_cnt,
// saturating counts of cycles each requester waited without a grant.
//
// Ports:
//   clk, rst_n              clock / asynchronous active-low reset
//   ireq, iaddr             fetch request and byte address (held until ignt)
//   ignt                    fetch accepted this cycle
//   irvalid, irdata         fetch return
//   dreq, dwe, daddr, dwdata data request (held until dgnt)
//   dgnt                    data access accepted this cycle
//   drvalid, drdata         data read return
//   mem_addr, mem_we, mem_din  MemArray address / write enable / write data
//   mem_dout                MemArray read data, READ_LAT cycles after address
//   istall_cnt, dstall_cnt  stall counters (ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int               DBITS       = 16,
    parameter int               ABITS       = 12,
    parameter int               READ_LAT    = 1,
    parameter int               MAX_DSTREAK = 3,
    parameter logic [DBITS-1:0] POISON      = DBITS'(POISON_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ireq,
    input  logic [DBITS-1:0] iaddr,
    output logic             ignt,
    output logic             irvalid,
    output logic [DBITS-1:0] irdata,
    input  logic             dreq,
    input  logic             dwe,
    input  logic [DBITS-1:0] daddr,
    input  logic [DBITS-1:0] dwdata,
    output logic             dgnt,
    output logic             drvalid,
    output logic [DBITS-1:0] drdata,
    output logic [ABITS-1:0] mem_addr,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_din,
    input  logic [DBITS-1:0] mem_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      istall_cnt,
    output logic [15:0]      dstall_cnt
`endif
);

    localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    logic [SW-1:0]    streak;
    logic [ABITS-1:0] addr_q;
    logic             i_in;
    logic             d_in;
    logic             d_yield;
    ret_entry_t       push_entry;
    ret_entry_t       pop_entry;
    logic [DBITS-1:0] ret_data;

    assign i_in = in_region(ADDR_MAX'(iaddr), ABITS);
    assign d_in = in_region(ADDR_MAX'(daddr), ABITS);

    // Grant decision. Data normally has priority; once it has taken
    // MAX_DSTREAK grants in a row while a fetch is waiting it must yield.
    // Grants are forced low while reset is asserted even though they are
    // purely combinational from the requests.
    always_comb begin
        d_yield = ireq && (streak == STREAK_MAX);
        dgnt    = 1'b0;
        ignt    = 1'b0;
        if (rst_n) begin
            dgnt = dreq && !d_yield;
            ignt = ireq && !dgnt;
        end
    end

    // Streak of data grants that went ahead of a waiting fetch. Any cycle
    // without a fetch request, or a fetch grant, ends the streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (!ireq || ignt) begin
            streak <= '0;
        end else if (dgnt && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    // Memory address mux: the granted requester's word address, otherwise
    // the last address driven, so the memory sees a stable port when idle.
    always_comb begin
        mem_addr = addr_q;
        if (ignt) begin
            mem_addr = iaddr[ABITS:1];
        end else if (dgnt) begin
            mem_addr = daddr[ABITS:1];
        end
    end

    // Registered copy of the address last presented to the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= mem_addr;
        end
    end

    // Out-of-region writes are accepted (granted) but never reach memory.
    assign mem_we  = dgnt && dwe && d_in;
    assign mem_din = dwdata;

    // Describe this cycle's access for the return pipe. Writes and idle
    // cycles push a bubble so the pipe timing stays aligned with memory.
    always_comb begin
        push_entry       = '0;
        push_entry.owner = OWN_D;
        if (ignt) begin
            push_entry.valid = 1'b1;
            push_entry.owner = OWN_I;
            push_entry.oor   = !i_in;
        end else if (dgnt && !dwe) begin
            push_entry.valid = 1'b1;
            push_entry.owner = OWN_D;
            push_entry.oor   = !d_in;
        end
    end

    arb_ret_pipe #(
        .READ_LAT (READ_LAT)
    ) u_ret_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_entry (push_entry),
        .pop_entry  (pop_entry)
    );

    // Route the popped return to its owner. Data outputs are zero whenever
    // the matching valid is low, which also makes them read 0 in reset.
    always_comb begin
        ret_data = pop_entry.oor ? POISON : mem_dout;
        irvalid  = pop_entry.valid && (pop_entry.owner == OWN_I);
        drvalid  = pop_entry.valid && (pop_entry.owner == OWN_D);
        irdata   = irvalid ? ret_data : '0;
        drdata   = drvalid ? ret_data : '0;
    end

`ifdef ARB_STATS_EN
    // Saturating stall counters: cycles a requester asked and was refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            istall_cnt <= '0;
            dstall_cnt <= '0;
        end else begin
            if (ireq && !ignt && (istall_cnt != 16'hFFFF)) begin
                istall_cnt <= istall_cnt + 16'd1;
            end
            if (dreq && !dgnt && (dstall_cnt != 16'hFFFF)) begin
                dstall_cnt <= dstall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
